// File: rtl/mem_stage_ctrl.sv
// Purpose: MEM-stage controller; issues data-memory req/ack accesses and drives the MEM/WB pipeline register.
// Latency: 1 cycle for non-memory ops; memory ops take IDLE + >=1 ACCESS cycle (completes on the dm_ack_i edge).
// Backpressure: stall_o freezes upstream while an access is outstanding; optional MEM_TIMEOUT_EN aborts long accesses.
module mem_stage_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [31:0]       instr_i,
    input  logic [31:0]       alu_res_i,
    input  logic [31:0]       read_data_2_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [1:0]        MemtoReg_i,
    input  logic              RegWrite_i,
    output logic              dm_req_o,
    output logic              dm_we_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [31:0]       dm_wdata_o,
    input  logic              dm_ack_i,
    input  logic [31:0]       dm_rdata_i,
    output logic              stall_o,
    output logic [31:0]       instr_o,
    output logic [31:0]       alu_res_o,
    output logic [31:0]       mem_data_o,
    output logic [1:0]        MemtoReg_o,
    output logic              RegWrite_o,
    output logic              err_o
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // operation captured when a memory access is launched
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_we;
    logic [31:0]         r_instr;
    logic [1:0]          r_memtoreg;
    logic                r_regwrite;

    // MEM/WB pipeline register
    logic [31:0]         r_instr_o;
    logic [31:0]         r_alu_res_o;
    logic [31:0]         r_mem_data_o;
    logic [1:0]          r_memtoreg_o;
    logic                r_regwrite_o;

    logic                w_mem_op;
    logic                w_in_access;
    logic                w_latch;
    logic                w_stall;
    logic                w_abort;
    logic [31:0]         w_addr_ext;
    logic [31:0]         w_instr_nxt;
    logic [31:0]         w_alu_nxt;
    logic [31:0]         w_mem_data_nxt;
    logic [1:0]          w_memtoreg_nxt;
    logic                w_regwrite_nxt;

    assign w_mem_op    = MemRead_i | MemWrite_i;
    assign w_in_access = (r_state == S_ACCESS);
    assign w_addr_ext  = 32'(r_addr);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;

    // An ack in the final allowed cycle wins over the abort.
    assign w_abort = w_in_access & ~dm_ack_i & (r_cnt == CNT_LAST);
    assign err_o   = r_err;

    // Count unacknowledged ACCESS cycles; raise a sticky error on abort.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_mem_op) begin
                r_cnt <= '0;
            end else if (w_in_access && !dm_ack_i && !w_abort) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_abort = 1'b0;
    assign err_o   = 1'b0;
`endif

    // Next-state, stall and MEM/WB next-value selection.
    always_comb begin
        w_state_nxt    = r_state;
        w_latch        = 1'b0;
        w_stall        = 1'b0;
        w_instr_nxt    = r_instr_o;
        w_alu_nxt      = r_alu_res_o;
        w_mem_data_nxt = r_mem_data_o;
        w_memtoreg_nxt = r_memtoreg_o;
        w_regwrite_nxt = r_regwrite_o;
        case (r_state)
            S_IDLE: begin
                if (!w_mem_op) begin
                    w_instr_nxt    = instr_i;
                    w_alu_nxt      = alu_res_i;
                    w_memtoreg_nxt = MemtoReg_i;
                    w_regwrite_nxt = RegWrite_i;
                end else begin
                    w_latch        = 1'b1;
                    w_stall        = 1'b1;
                    w_state_nxt    = S_ACCESS;
                    w_instr_nxt    = 32'h0;
                    w_regwrite_nxt = 1'b0;
                end
            end
            S_ACCESS: begin
                if (dm_ack_i) begin
                    w_state_nxt    = S_IDLE;
                    w_instr_nxt    = r_instr;
                    w_alu_nxt      = w_addr_ext;
                    w_memtoreg_nxt = r_memtoreg;
                    w_regwrite_nxt = r_regwrite;
                    if (!r_we) begin
                        w_mem_data_nxt = dm_rdata_i;
                    end
                end else if (w_abort) begin
                    w_state_nxt    = S_IDLE;
                    w_instr_nxt    = r_instr;
                    w_alu_nxt      = w_addr_ext;
                    w_memtoreg_nxt = r_memtoreg;
                    w_regwrite_nxt = 1'b0;
                    w_mem_data_nxt = 32'h0;
                end else begin
                    w_stall        = 1'b1;
                    w_instr_nxt    = 32'h0;
                    w_regwrite_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the memory operation when it launches; a combined read+write is a write.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_we       <= 1'b0;
            r_instr    <= 32'h0;
            r_memtoreg <= 2'b00;
            r_regwrite <= 1'b0;
        end else if (w_latch) begin
            r_addr     <= alu_res_i[ADDR_W-1:0];
            r_wdata    <= read_data_2_i;
            r_we       <= MemWrite_i;
            r_instr    <= instr_i;
            r_memtoreg <= MemtoReg_i;
            r_regwrite <= RegWrite_i;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_o    <= 32'h0;
            r_alu_res_o  <= 32'h0;
            r_mem_data_o <= 32'h0;
            r_memtoreg_o <= 2'b00;
            r_regwrite_o <= 1'b0;
        end else begin
            r_instr_o    <= w_instr_nxt;
            r_alu_res_o  <= w_alu_nxt;
            r_mem_data_o <= w_mem_data_nxt;
            r_memtoreg_o <= w_memtoreg_nxt;
            r_regwrite_o <= w_regwrite_nxt;
        end
    end

    // Memory interface is quiet outside ACCESS; reset also masks the upstream stall.
    assign dm_req_o   = w_in_access;
    assign dm_we_o    = w_in_access & r_we;
    assign dm_addr_o  = w_in_access ? r_addr : '0;
    assign dm_wdata_o = w_in_access ? r_wdata : 32'h0;
    assign stall_o    = rst_n & w_stall;

    assign instr_o    = r_instr_o;
    assign alu_res_o  = r_alu_res_o;
    assign mem_data_o = r_mem_data_o;
    assign MemtoReg_o = r_memtoreg_o;
    assign RegWrite_o = r_regwrite_o;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Purpose: scoreboard bench for mem_stage_ctrl with a req/ack memory responder.
// Latency: expected writebacks are queued at issue and popped on every non-stalled edge.
// Backpressure: each issue waits (bounded) for stall_o to drop before the next op.
module tb_mem_stage_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i, alu_res_i, read_data_2_i;
    logic        MemRead_i, MemWrite_i;
    logic [1:0]  MemtoReg_i;
    logic        RegWrite_i;
    logic        dm_req_o, dm_we_o;
    logic [31:0] dm_addr_o, dm_wdata_o;
    logic        dm_ack_i;
    logic [31:0] dm_rdata_i;
    logic        stall_o;
    logic [31:0] instr_o, alu_res_o, mem_data_o;
    logic [1:0]  MemtoReg_o;
    logic        RegWrite_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    mem_stage_ctrl #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .instr_i(instr_i), .alu_res_i(alu_res_i), .read_data_2_i(read_data_2_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i),
        .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o),
        .dm_ack_i(dm_ack_i), .dm_rdata_i(dm_rdata_i),
        .stall_o(stall_o),
        .instr_o(instr_o), .alu_res_o(alu_res_o), .mem_data_o(mem_data_o),
        .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
        .err_o(err_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] mdata;
        logic [1:0]  mtr;
        logic        rw;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } acc_t;

    wb_t         wb_q[$];
    acc_t        acc_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_mem_data = 32'h0;
    int          g_ack_delay = 1;
    logic [31:0] g_rdata = 32'h0;
    logic        g_force_ack = 1'b0;
    bit          mon_en = 1'b0;
    int          last_len = 0;
    int          last_gap = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every edge not preceded by a stall carries a writeback, otherwise a bubble.
    initial begin
        bit  ok;
        bit  adv;
        wb_t e;
        forever begin
            @(negedge clk_i);
            ok  = mon_en && (rst_n === 1'b1);
            adv = (stall_o === 1'b0);
            @(posedge clk_i);
            #1;
            if (ok && mon_en && rst_n === 1'b1) begin
                if (adv) begin
                    if (wb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL wb_unexpected: got instr %h want no writeback", instr_o);
                    end else begin
                        e = wb_q.pop_front();
                        chk("wb_instr", instr_o, e.instr);
                        chk("wb_alu", alu_res_o, e.alu);
                        chk("wb_mem_data", mem_data_o, e.mdata);
                        chk("wb_memtoreg", {30'h0, MemtoReg_o}, {30'h0, e.mtr});
                        chk("wb_regwrite", {31'h0, RegWrite_o}, {31'h0, e.rw});
                    end
                end else begin
                    chk("bubble_instr", instr_o, 32'h0);
                    chk("bubble_regwrite", {31'h0, RegWrite_o}, 32'h0);
                end
            end
        end
    end

    // Memory responder: acks in the g_ack_delay-th request cycle, checks request fields.
    initial begin
        bit   prev = 1'b0;
        int   cnt  = 0;
        int   low  = 100;
        acc_t cur;
        cur = '{addr: 32'h0, wdata: 32'h0, we: 1'b0};
        dm_ack_i   = 1'b0;
        dm_rdata_i = 32'h0;
        forever begin
            @(posedge clk_i);
            #2;
            if (dm_req_o === 1'b1) begin
                if (!prev) begin
                    last_gap = low;
                    cnt      = 0;
                    if (acc_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL dm_unexpected_req: got addr %h want no request", dm_addr_o);
                    end else begin
                        cur = acc_q.pop_front();
                    end
                end
                cnt++;
                chk("dm_addr", dm_addr_o, cur.addr);
                chk("dm_we", {31'h0, dm_we_o}, {31'h0, cur.we});
                chk("dm_wdata", dm_wdata_o, cur.wdata);
                dm_ack_i   = (cnt == g_ack_delay);
                dm_rdata_i = dm_ack_i ? g_rdata : 32'h0;
                prev = 1'b1;
            end else begin
                if (prev) begin
                    last_len = cnt;
                    low      = 0;
                end
                low++;
                if (mon_en) begin
                    chk("idle_dm_addr", dm_addr_o, 32'h0);
                end
                dm_ack_i   = g_force_ack;
                dm_rdata_i = 32'h0;
                prev = 1'b0;
            end
        end
    end

    // Drive one op, queue its expected writeback/access, wait for it to leave MEM.
    task automatic issue(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] rd2,
                         input logic mr, input logic mw, input logic [1:0] mtr, input logic rw,
                         input int delay, input logic [31:0] rdata, input bit abort,
                         output int stalls);
        wb_t  e;
        acc_t a;
        int   n;
        instr_i       = instr;
        alu_res_i     = alu;
        read_data_2_i = rd2;
        MemRead_i     = mr;
        MemWrite_i    = mw;
        MemtoReg_i    = mtr;
        RegWrite_i    = rw;
        g_ack_delay   = delay;
        g_rdata       = rdata;
        if (mr | mw) begin
            a.addr  = alu;
            a.we    = mw;
            a.wdata = rd2;
            acc_q.push_back(a);
        end
        if (abort) m_mem_data = 32'h0;
        else if (mr & ~mw) m_mem_data = rdata;
        e.instr = instr;
        e.alu   = alu;
        e.mtr   = mtr;
        e.rw    = rw & ~abort;
        e.mdata = m_mem_data;
        wb_q.push_back(e);
        stalls = 0;
        for (n = 0; n < 80; n++) begin
            @(negedge clk_i);
            if (stall_o === 1'b0) break;
            stalls++;
        end
        if (n == 80) begin
            total++;
            bad++;
            $display("FAIL stall_timeout: got stall_o=1 for 80 cycles want release");
        end
        @(posedge clk_i);
        #3;
    endtask

    initial begin
        int st;
        rst_n = 1'b0;
        instr_i = 32'h0; alu_res_i = 32'h0; read_data_2_i = 32'h0;
        MemRead_i = 1'b0; MemWrite_i = 1'b0; MemtoReg_i = 2'b00; RegWrite_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_dm_req", {31'h0, dm_req_o}, 32'h0);
        chk("rst_stall", {31'h0, stall_o}, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_alu", alu_res_o, 32'h0);
        chk("rst_mem_data", mem_data_o, 32'h0);
        chk("rst_regwrite", {31'h0, RegWrite_o}, 32'h0);
        chk("rst_err", {31'h0, err_o}, 32'h0);
        @(posedge clk_i);
        #3;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // ALU op passes straight through.
        issue(32'h012A4020, 32'h55, 32'h0, 1'b0, 1'b0, 2'b00, 1'b1, 1, 32'h0, 1'b0, st);
        chk("alu_stalls", st, 0);
        // Load acked in the third ACCESS cycle.
        issue(32'h8C080040, 32'h40, 32'h77, 1'b1, 1'b0, 2'b01, 1'b1, 3, 32'hDEADBEEF, 1'b0, st);
        chk("load_stalls", st, 3);
        chk("load_req_len", last_len, 3);
        // Store acked immediately; load data holds.
        issue(32'hAC090080, 32'h80, 32'h1234, 1'b0, 1'b1, 2'b00, 1'b0, 1, 32'h0, 1'b0, st);
        chk("store_stalls", st, 1);
        chk("store_req_len", last_len, 1);
        // Back-to-back loads.
        issue(32'h8C0B0010, 32'h10, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1, 32'hA5A50001, 1'b0, st);
        chk("b2b_first_stalls", st, 1);
        issue(32'h8C0C0014, 32'h14, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1, 32'h5A5A0002, 1'b0, st);
        chk("b2b_second_stalls", st, 1);
        chk("b2b_req_gap", last_gap, 1);
        // Read and write together behave as a write.
        issue(32'hAC0D0020, 32'h20, 32'hCAFE0001, 1'b1, 1'b1, 2'b01, 1'b1, 2, 32'hBAD0BAD0, 1'b0, st);
        chk("rw_both_stalls", st, 2);
        // Stray ack while idle is ignored.
        g_force_ack = 1'b1;
        issue(32'h00851020, 32'h99, 32'h0, 1'b0, 1'b0, 2'b00, 1'b1, 1, 32'h0, 1'b0, st);
        chk("idle_ack_stalls", st, 0);
        g_force_ack = 1'b0;
        issue(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1, 32'h0, 1'b0, st);

        // Reset in the middle of an access.
        mon_en        = 1'b0;
        g_ack_delay   = 1000;
        instr_i       = 32'h8C110100;
        alu_res_i     = 32'h100;
        read_data_2_i = 32'h0;
        MemRead_i     = 1'b1;
        RegWrite_i    = 1'b1;
        MemtoReg_i    = 2'b01;
        acc_q.push_back('{addr: 32'h100, wdata: 32'h0, we: 1'b0});
        repeat (3) @(posedge clk_i);
        #4;
        chk("midrst_pre_req", {31'h0, dm_req_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_dm_req", {31'h0, dm_req_o}, 32'h0);
        chk("midrst_stall", {31'h0, stall_o}, 32'h0);
        chk("midrst_regwrite", {31'h0, RegWrite_o}, 32'h0);
        chk("midrst_instr", instr_o, 32'h0);
        chk("midrst_mem_data", mem_data_o, 32'h0);
        instr_i = 32'h0; alu_res_i = 32'h0; MemRead_i = 1'b0; RegWrite_i = 1'b0; MemtoReg_i = 2'b00;
        @(posedge clk_i);
        #3;
        rst_n      = 1'b1;
        m_mem_data = 32'h0;
        mon_en     = 1'b1;
        issue(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1, 32'h0, 1'b0, st);
        chk("postrst_stalls", st, 0);
        issue(32'h8C0E0044, 32'h44, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 2, 32'h13579BDF, 1'b0, st);
        chk("postrst_load_stalls", st, 2);

`ifdef MEM_TIMEOUT_EN
        // Ack in the last allowed cycle completes normally.
        issue(32'h8C0F0048, 32'h48, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 16, 32'h0BADF00D, 1'b0, st);
        chk("late_ack_stalls", st, 16);
        chk("late_ack_err", {31'h0, err_o}, 32'h0);
        // No ack: abort after 16 ACCESS cycles.
        issue(32'h8C100050, 32'h50, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1000, 32'h0, 1'b1, st);
        chk("abort_stalls", st, 16);
        chk("abort_req_len", last_len, 16);
        chk("abort_err", {31'h0, err_o}, 32'h1);
        issue(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1, 32'h0, 1'b0, st);
        chk("abort_err_sticky", {31'h0, err_o}, 32'h1);
`else
        chk("err_tied_low", {31'h0, err_o}, 32'h0);
`endif

        issue(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1, 32'h0, 1'b0, st);
        mon_en = 1'b0;
        chk("wb_queue_drained", wb_q.size(), 0);
        chk("acc_queue_drained", acc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller; the consuming end of the EX/MEM pipeline register.
- Takes the registered EX/MEM outputs: ALU result, store data, memory and writeback controls, and instruction.
- Runs a req/ack handshake with a variable-latency data memory and stalls upstream until the access completes.
- Drives the MEM/WB pipeline register outputs consumed by the writeback stage.

Parameters:
- ADDR_W, 32, data-memory address width (low bits of alu_res_i).
- TIMEOUT, 16, max ACCESS cycles before abort (only with MEM_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_i  in  32  instruction from EX/MEM.
- alu_res_i  in  32  ALU result / memory address from EX/MEM.
- read_data_2_i  in  32  store data from EX/MEM.
- MemRead_i  in  1  load request.
- MemWrite_i  in  1  store request.
- MemtoReg_i  in  2  writeback select, passed through.
- RegWrite_i  in  1  register write enable, passed through.
- dm_req_o  out  1  memory request.
- dm_we_o  out  1  1 = write.
- dm_addr_o  out  ADDR_W  memory address.
- dm_wdata_o  out  32  store data.
- dm_ack_i  in  1  memory completion, one-cycle pulse.
- dm_rdata_i  in  32  load data, valid with dm_ack_i.
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- instr_o  out  32  MEM/WB instruction.
- alu_res_o  out  32  MEM/WB ALU result.
- mem_data_o  out  32  MEM/WB load data.
- MemtoReg_o  out  2  MEM/WB writeback select.
- RegWrite_o  out  1  MEM/WB register write enable.
- err_o  out  1  sticky timeout error (MEM_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All registered outputs are 0. dm_req_o=0 immediately, including when reset hits mid-access. Any pending access is dropped and no writeback occurs.
- mem_op = MemRead_i | MemWrite_i.
- If MemRead_i and MemWrite_i are both 1, the access is treated as a write.
- State IDLE:
  - mem_op=0: the MEM/WB register loads instr_i, alu_res_i, MemtoReg_i and RegWrite_i each cycle. mem_data_o holds its previous value. stall_o=0.
  - mem_op=1: latch addr=alu_res_i[ADDR_W-1:0], wdata=read_data_2_i, we=MemWrite_i, and the controls. Go to ACCESS. stall_o=1 combinationally. MEM/WB loads a bubble: instr_o=0, RegWrite_o=0, other fields hold.
- State ACCESS:
  - dm_req_o=1. dm_we_o, dm_addr_o and dm_wdata_o are held stable from the latched values.
  - stall_o = ~dm_ack_i.
  - dm_ack_i=0: MEM/WB loads a bubble; stay in ACCESS.
  - dm_ack_i=1: MEM/WB loads the latched instr, addr (into alu_res_o), MemtoReg and RegWrite. mem_data_o=dm_rdata_i for a load and holds for a store. Return to IDLE. Upstream advances on this edge.
- dm_req_o, dm_we_o, dm_addr_o and dm_wdata_o are 0 in IDLE.
- Latency: a memory op occupies at least 2 cycles (IDLE + ACCESS with ack). A non-memory op takes 1 cycle.
- Back-to-back memory ops: after the ack edge, the next mem op is in IDLE and issues immediately. dm_req_o drops for exactly one cycle between accesses.
- dm_ack_i received in IDLE is ignored.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: a cycle counter clears on entry to ACCESS and increments each ACCESS cycle without ack. On reaching TIMEOUT, the access aborts:
  - dm_req_o drops; return to IDLE; stall_o=0 that cycle.
  - MEM/WB loads the op with RegWrite_o forced 0 and mem_data_o=0.
  - err_o sets and stays 1 until reset.
  - An ack arriving in the same cycle as timeout wins: normal completion, no error.
- Undefined: no counter; ACCESS waits indefinitely; err_o=0.

Test Plan:
- Reset mid-ACCESS with dm_req_o=1, rst_n pulsed low -> dm_req_o=0, stall_o=0, RegWrite_o=0, instr_o=0 same cycle.
- ALU op instr_i=0x012A4020, alu_res_i=0x55, RegWrite_i=1 -> next edge instr_o=0x012A4020, alu_res_o=0x55, RegWrite_o=1, stall_o=0 throughout.
- Load alu_res_i=0x40, ack after 3 ACCESS cycles with dm_rdata_i=0xDEADBEEF -> dm_req_o high 3 cycles with dm_addr_o=0x40; stall_o high 3 cycles then low on the ack cycle; mem_data_o=0xDEADBEEF, RegWrite_o=1; bubbles (RegWrite_o=0) before that.
- Store alu_res_i=0x80, read_data_2_i=0x1234, ack in first ACCESS cycle -> dm_we_o=1, dm_wdata_o=0x1234 for 1 cycle; mem_data_o unchanged.
- Two back-to-back loads (0x10, 0x14), immediate acks -> two requests separated by one dm_req_o=0 cycle, both writebacks in order.
- MEM_TIMEOUT_EN, TIMEOUT=16, no ack -> abort after 16 ACCESS cycles, err_o=1 sticky, RegWrite_o=0, mem_data_o=0; ack at cycle 16 -> no error.
